// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//
// Owns the single register-file write port. Each cycle it grants the port
// to at most one requester: the in-order pipeline result (pc/alu/imm
// sources) or the oldest returning load (mem source). A pending load that
// keeps losing to the pipeline is forced through after STARVE_MAX losses.
// The grant steers the select of the registered 4:1 write-back mux.
// rf_we/rf_waddr are registered, so they line up with that mux's output.
// Destinations of outstanding loads are kept in an in-order circular FIFO.
// That FIFO, plus the write currently being presented, feeds the RAW
// hazard flags for the decode stage.
//
// Ports
//   clk, rst_n         clock (posedge) and asynchronous active-low reset
//   pipe_valid/src/rd  pipeline write request, mux source, destination
//   pipe_ready         pipeline request granted this cycle
//   ld_issue/_rd       load issued to memory and its destination
//   ld_issue_ready     load FIFO has room
//   ld_valid           oldest load's data is on the mux mem input
//   ld_ready           returning load granted this cycle
//   rs1, rs2           decode-stage source registers
//   rs1/rs2_hazard     source value not yet in the register file
//   wb_sel             write-back mux select
//   rf_we, rf_waddr    register-file write strobe and address (registered)
//   wb_err             sticky protocol-error flag

module wb_port_arbiter #(
  parameter int NUM_LOAD_OUT = 4,
  parameter int STARVE_MAX   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pipe_valid,
  input  logic [1:0] pipe_src,
  input  logic [4:0] pipe_rd,
  output logic       pipe_ready,
  input  logic       ld_issue,
  input  logic [4:0] ld_issue_rd,
  output logic       ld_issue_ready,
  input  logic       ld_valid,
  output logic       ld_ready,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       rs1_hazard,
  output logic       rs2_hazard,
  output logic [1:0] wb_sel,
  output logic       rf_we,
  output logic [4:0] rf_waddr,
  output logic       wb_err
);

  localparam int PW = (NUM_LOAD_OUT > 1) ? $clog2(NUM_LOAD_OUT) : 1;
  localparam int CW = $clog2(NUM_LOAD_OUT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] SEL_ALU     = 2'd1;
  localparam logic [1:0] SEL_MEM     = 2'd2;
  localparam logic [1:0] SRC_ILLEGAL = 2'd2;

  // Load destination FIFO
  logic [4:0]              ldRd_q [NUM_LOAD_OUT];
  logic [NUM_LOAD_OUT-1:0] entryValid_q, entryValid_d;
  logic [PW-1:0]           wrPtr_q, wrPtr_d;
  logic [PW-1:0]           rdPtr_q, rdPtr_d;
  logic [CW-1:0]           count_q, count_d;

  // Arbitration and write-port state
  logic [SW-1:0]           starve_q, starve_d;
  logic                    rfWe_q, rfWe_d;
  logic [4:0]              rfWaddr_q, rfWaddr_d;
  logic                    wbErr_q, wbErr_d;

  logic                    fifoEmpty, fifoFull;
  logic                    pipeReq, ldEligible, starveMax;
  logic                    ldGrant, pipeGrant, anyGrant;
  logic                    push;
  logic [4:0]              headRd, grantRd;
  logic                    hit1, hit2;

  function automatic logic [PW-1:0] ptrNext(input logic [PW-1:0] p);
    return (p == PW'(NUM_LOAD_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  // Arbitration. An illegal pipe source is not a real request, so it
  // neither wins the port nor holds off a returning load.
  always_comb begin
    fifoEmpty  = (count_q == '0);
    fifoFull   = (count_q == CW'(NUM_LOAD_OUT));
    pipeReq    = pipe_valid && (pipe_src != SRC_ILLEGAL);
    ldEligible = ld_valid && !fifoEmpty;
    starveMax  = (starve_q == SW'(STARVE_MAX));
    ldGrant    = ldEligible && (!pipeReq || starveMax);
    pipeGrant  = pipeReq && !ldGrant;
    anyGrant   = ldGrant || pipeGrant;
    push       = ld_issue && !fifoFull;
    headRd     = ldRd_q[rdPtr_q];
    grantRd    = ldGrant ? headRd : pipe_rd;
  end

  always_comb begin
    if (ldGrant) begin
      wb_sel = SEL_MEM;
    end else if (pipeGrant) begin
      wb_sel = pipe_src;
    end else begin
      wb_sel = SEL_ALU;
    end
  end

  // Next-state logic. Full is judged before any same-cycle pop, so a
  // pop never opens a slot for a push in the same cycle.
  always_comb begin
    entryValid_d = entryValid_q;
    wrPtr_d      = wrPtr_q;
    rdPtr_d      = rdPtr_q;
    count_d      = count_q;
    starve_d     = '0;
    rfWe_d       = anyGrant && (grantRd != 5'd0);
    rfWaddr_d    = anyGrant ? grantRd : rfWaddr_q;
    wbErr_d      = wbErr_q
                   || (ld_valid && fifoEmpty)
                   || (pipe_valid && (pipe_src == SRC_ILLEGAL))
                   || (ld_issue && fifoFull);

    if (ldGrant) begin
      entryValid_d[rdPtr_q] = 1'b0;
      rdPtr_d               = ptrNext(rdPtr_q);
    end
    if (push) begin
      entryValid_d[wrPtr_q] = 1'b1;
      wrPtr_d               = ptrNext(wrPtr_q);
    end

    case ({push, ldGrant})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A losing eligible load ages; any other outcome restarts the count.
    if (ldEligible && !ldGrant) begin
      starve_d = starveMax ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LOAD_OUT; i++) begin
        ldRd_q[i] <= '0;
      end
      entryValid_q <= '0;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      rfWe_q       <= 1'b0;
      rfWaddr_q    <= '0;
      wbErr_q      <= 1'b0;
    end else begin
      if (push) begin
        ldRd_q[wrPtr_q] <= ld_issue_rd;
      end
      entryValid_q <= entryValid_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      rfWe_q       <= rfWe_d;
      rfWaddr_q    <= rfWaddr_d;
      wbErr_q      <= wbErr_d;
    end
  end

  // RAW hazards: any live FIFO entry (including the one popping now) or
  // the write being presented to the register file this cycle.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < NUM_LOAD_OUT; i++) begin
      if (entryValid_q[i] && (ldRd_q[i] == rs1)) hit1 = 1'b1;
      if (entryValid_q[i] && (ldRd_q[i] == rs2)) hit2 = 1'b1;
    end
    rs1_hazard = (rs1 != 5'd0) && (hit1 || (rfWe_q && (rfWaddr_q == rs1)));
    rs2_hazard = (rs2 != 5'd0) && (hit2 || (rfWe_q && (rfWaddr_q == rs2)));
  end

  assign pipe_ready     = pipeGrant;
  assign ld_ready       = ldGrant;
  assign ld_issue_ready = !fifoFull;
  assign rf_we          = rfWe_q;
  assign rf_waddr       = rfWaddr_q;
  assign wb_err         = wbErr_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios plus randomized traffic,
// checked against a queue-based reference model. Expected register-file
// writes go into a scoreboard queue that a negedge monitor drains.
module tb_wb_port_arbiter;

  localparam int N  = 4;
  localparam int SM = 3;

  logic       clk;
  logic       rst_n;
  logic       pipe_valid;
  logic [1:0] pipe_src;
  logic [4:0] pipe_rd;
  logic       pipe_ready;
  logic       ld_issue;
  logic [4:0] ld_issue_rd;
  logic       ld_issue_ready;
  logic       ld_valid;
  logic       ld_ready;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       rs1_hazard;
  logic       rs2_hazard;
  logic [1:0] wb_sel;
  logic       rf_we;
  logic [4:0] rf_waddr;
  logic       wb_err;

  wb_port_arbiter #(.NUM_LOAD_OUT(N), .STARVE_MAX(SM)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pipe_valid     (pipe_valid),
    .pipe_src       (pipe_src),
    .pipe_rd        (pipe_rd),
    .pipe_ready     (pipe_ready),
    .ld_issue       (ld_issue),
    .ld_issue_rd    (ld_issue_rd),
    .ld_issue_ready (ld_issue_ready),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .rs1            (rs1),
    .rs2            (rs2),
    .rs1_hazard     (rs1_hazard),
    .rs2_hazard     (rs2_hazard),
    .wb_sel         (wb_sel),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .wb_err         (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: outstanding loads in issue order, starvation age,
  // the write being presented this cycle, and the sticky error.
  bit [4:0] mdlLoadQ[$];
  int       mdlStarve;
  bit       mdlLastWe;
  bit [4:0] mdlLastAddr;
  bit       mdlErr;

  // Scoreboard of register-file writes still to appear on rf_we/rf_waddr.
  bit [4:0] expWriteQ[$];

  task automatic checkValue(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented write must be the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      if (expWriteQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected write: rf_waddr=%0d, expected no write (t=%0t)",
                 rf_waddr, $time);
      end else begin
        checkValue("rf_waddr", int'(rf_waddr), int'(expWriteQ.pop_front()));
      end
    end
  end

  function automatic bit mdlHazard(input bit [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    foreach (mdlLoadQ[i]) if (mdlLoadQ[i] == rs) return 1'b1;
    return mdlLastWe && (mdlLastAddr == rs);
  endfunction

  task automatic mdlReset();
    mdlLoadQ.delete();
    expWriteQ.delete();
    mdlStarve   = 0;
    mdlLastWe   = 1'b0;
    mdlLastAddr = 5'd0;
    mdlErr      = 1'b0;
  endtask

  // Compare the current cycle's outputs against the model, then advance it.
  task automatic checkOutput();
    bit       full, pipeReq, eligible, ldWin, pipeWin;
    bit [4:0] rd;
    int       expSel;
    full     = (mdlLoadQ.size() >= N);
    pipeReq  = pipe_valid && (pipe_src != 2'd2);
    eligible = ld_valid && (mdlLoadQ.size() > 0);
    ldWin    = eligible && (!pipeReq || mdlStarve == SM);
    pipeWin  = pipeReq && !ldWin;
    expSel   = ldWin ? 2 : (pipeWin ? int'(pipe_src) : 1);

    checkValue("pipe_ready",     int'(pipe_ready),     int'(pipeWin));
    checkValue("ld_ready",       int'(ld_ready),       int'(ldWin));
    checkValue("wb_sel",         int'(wb_sel),         expSel);
    checkValue("ld_issue_ready", int'(ld_issue_ready), int'(!full));
    checkValue("rs1_hazard",     int'(rs1_hazard),     int'(mdlHazard(rs1)));
    checkValue("rs2_hazard",     int'(rs2_hazard),     int'(mdlHazard(rs2)));
    checkValue("wb_err",         int'(wb_err),         int'(mdlErr));

    if ((ld_valid && mdlLoadQ.size() == 0) || (pipe_valid && pipe_src == 2'd2) ||
        (ld_issue && full))
      mdlErr = 1'b1;

    if (ldWin || pipeWin) begin
      rd = ldWin ? mdlLoadQ.pop_front() : pipe_rd;
      if (rd != 5'd0) expWriteQ.push_back(rd);
      mdlLastWe   = (rd != 5'd0);
      mdlLastAddr = rd;
    end else begin
      mdlLastWe = 1'b0;
    end

    if (ld_issue && !full) mdlLoadQ.push_back(ld_issue_rd);

    if (eligible && !ldWin) mdlStarve = (mdlStarve < SM) ? mdlStarve + 1 : SM;
    else                    mdlStarve = 0;
  endtask

  task automatic applyStimulus(input bit pv, input bit [1:0] src, input bit [4:0] prd,
                               input bit li, input bit [4:0] lird, input bit ldv,
                               input bit [4:0] r1, input bit [4:0] r2);
    @(posedge clk);
    #1;
    pipe_valid  = pv;
    pipe_src    = src;
    pipe_rd     = prd;
    ld_issue    = li;
    ld_issue_rd = lird;
    ld_valid    = ldv;
    rs1         = r1;
    rs2         = r2;
    #3;
    checkOutput();
  endtask

  task automatic idleInputs();
    pipe_valid  = 1'b0;
    pipe_src    = 2'd0;
    pipe_rd     = 5'd0;
    ld_issue    = 1'b0;
    ld_issue_rd = 5'd0;
    ld_valid    = 1'b0;
  endtask

  // Reset pulse inside a cycle; outputs checked while rst_n is low.
  task automatic resetDut();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idleInputs();
    rs1 = 5'd5;
    rs2 = 5'd9;
    mdlReset();
    #2;
    checkValue("reset rf_we",          int'(rf_we),          0);
    checkValue("reset rf_waddr",       int'(rf_waddr),       0);
    checkValue("reset rs1_hazard",     int'(rs1_hazard),     0);
    checkValue("reset rs2_hazard",     int'(rs2_hazard),     0);
    checkValue("reset ld_issue_ready", int'(ld_issue_ready), 1);
    checkValue("reset wb_err",         int'(wb_err),         0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit [1:0] legalSrc [3];
    bit       li, ldv;
    legalSrc[0] = 2'd0;
    legalSrc[1] = 2'd1;
    legalSrc[2] = 2'd3;

    rst_n = 1'b0;
    idleInputs();
    rs1 = 5'd0;
    rs2 = 5'd0;
    mdlReset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset mid-traffic with two loads queued
    applyStimulus(0, 0, 0, 1, 5'd5, 0, 5'd5, 5'd9);
    applyStimulus(0, 0, 0, 1, 5'd9, 0, 5'd5, 5'd9);
    applyStimulus(0, 0, 0, 0, 0,    0, 5'd5, 5'd9);
    resetDut();

    // Pipeline imm write to x7
    applyStimulus(1, 2'd3, 5'd7, 0, 0, 0, 5'd7, 5'd0);
    applyStimulus(0, 0,    0,    0, 0, 0, 5'd7, 5'd0);

    // Loads to x5 then x9, hazard on x9 tracked throughout
    applyStimulus(0, 0, 0, 1, 5'd5, 0, 5'd9, 5'd5);
    applyStimulus(0, 0, 0, 1, 5'd9, 0, 5'd9, 5'd5);
    applyStimulus(0, 0, 0, 0, 0,    1, 5'd9, 5'd5);
    applyStimulus(0, 0, 0, 0, 0,    1, 5'd9, 5'd5);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 5'd9, 5'd5);

    // Starvation: load pending while pipe keeps requesting
    applyStimulus(0, 0, 0, 1, 5'd12, 0, 5'd12, 5'd0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 2'd1, 5'(20 + i), 0, 0, 1, 5'd12, 5'd20);
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd0, 5'd0);

    // Randomized traffic without protocol errors
    for (int c = 0; c < 600; c++) begin
      li  = ($urandom_range(0, 2) == 0) && (mdlLoadQ.size() < N);
      ldv = ($urandom_range(0, 1) == 1) && (mdlLoadQ.size() > 0);
      applyStimulus(($urandom_range(0, 3) != 0), legalSrc[$urandom_range(0, 2)],
                    5'($urandom_range(0, 7)), li, 5'($urandom_range(0, 7)), ldv,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    repeat (6) applyStimulus(0, 0, 0, 0, 0, (mdlLoadQ.size() > 0), 5'd1, 5'd2);

    // Fill the FIFO, overflow, then push+pop at count 3
    for (int i = 0; i < N; i++) applyStimulus(0, 0, 0, 1, 5'(i + 1), 0, 5'd3, 5'd4);
    applyStimulus(0, 0, 0, 1, 5'd30, 0, 5'd30, 5'd4);
    applyStimulus(0, 0, 0, 0, 0,     1, 5'd30, 5'd1);
    applyStimulus(0, 0, 0, 1, 5'd8,  1, 5'd8,  5'd2);
    applyStimulus(0, 0, 0, 0, 0,     0, 5'd8,  5'd3);
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 1, 5'd8, 5'd4);
    resetDut();

    // x0 writes, rs=0 never hazards, ld_valid with empty FIFO
    applyStimulus(1, 2'd1, 5'd0, 1, 5'd0, 0, 5'd0, 5'd0);
    applyStimulus(0, 0,    0,    0, 0,    1, 5'd0, 5'd0);
    applyStimulus(0, 0,    0,    0, 0,    1, 5'd0, 5'd0);
    applyStimulus(0, 0,    0,    0, 0,    0, 5'd0, 5'd0);
    applyStimulus(1, 2'd2, 5'd3, 0, 0,    0, 5'd3, 5'd0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 5'd3, 5'd0);

    checkValue("writes outstanding at end", expWriteQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
